ecc_apb_sequencer: RTL and testbench

APB master controller that drives the ECC encode/decode slave on behalf of one command requester.
- Accepts a command (operation, data, codeword width, noise).
- Programs the slave's four registers over APB, with the CTRL write last so that it launches the operation.
- Waits for operation_done, then captures data_out and num_of_errors.
- Returns the result on a valid/ready response port, with a timeout guard.

---
 rtl/ecc_apb_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer
//   APB master that programs the ECC encode/decode slave for a single
//   command requester, then waits for the slave to finish and returns the
//   result on a valid/ready response port.
//
//   Register write order per command: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL.
//   CTRL goes last because writing it launches the slave operation.
//
//   Optional feature (macro ECC_SEQ_SKIP_REDUNDANT_WR_EN):
//     - keeps shadow copies of DATA_IN, CODEWORD_WIDTH and NOISE;
//     - skips any write whose value equals a valid shadow;
//     - CTRL is always written;
//     - a timeout invalidates every shadow.
//
// Ports
//   clk, rst (async, active low)
//   cmd_*          : command request (valid/ready), latched on acceptance
//   rsp_*          : response (valid/ready), held stable until accepted
//   busy           : high in every state except IDLE
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : APB master, write-only, no PREADY
//   data_out, operation_done, num_of_errors : slave result inputs
module ecc_apb_sequencer #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_BASE       = 0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [AMBA_WORD-1:0]       cmd_data,
  input  logic [1:0]                 cmd_width,
  input  logic [AMBA_WORD-1:0]       cmd_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

  // Register index equals the word offset from ADDR_BASE.
  localparam logic [1:0] R_CTRL  = 2'd0;
  localparam logic [1:0] R_DIN   = 2'd1;
  localparam logic [1:0] R_CW    = 2'd2;
  localparam logic [1:0] R_NOISE = 2'd3;

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                     state_q,  state_d;
  logic [1:0]                 idx_q,    idx_d;
  logic [1:0]                 op_q,     op_d;
  logic [AMBA_WORD-1:0]       data_q,   data_d;
  logic [1:0]                 width_q,  width_d;
  logic [AMBA_WORD-1:0]       noise_q,  noise_d;
  logic [CNT_W-1:0]           cnt_q,    cnt_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q,  paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]      rdata_q,  rdata_d;
  logic [1:0]                 rerr_q,   rerr_d;
  logic                       rto_q,    rto_d;

  // Command values in effect this cycle.
  // In IDLE these come straight from the port, so the first SETUP can be
  // loaded on the accept edge.
  logic                 in_idle;
  logic [1:0]           v_op;
  logic [1:0]           v_width;
  logic [AMBA_WORD-1:0] v_data;
  logic [AMBA_WORD-1:0] v_noise;

  assign in_idle = (state_q == S_IDLE);
  assign v_op    = in_idle ? cmd_op    : op_q;
  assign v_data  = in_idle ? cmd_data  : data_q;
  assign v_width = in_idle ? cmd_width : width_q;
  assign v_noise = in_idle ? cmd_noise : noise_q;

  logic timeout_evt;
  assign timeout_evt = (state_q == S_WAIT) && !operation_done && (cnt_q == CNT_LAST);

  // skip[i] : register i need not be written for the current command
  logic [3:1] skip;

`ifdef ECC_SEQ_SKIP_REDUNDANT_WR_EN
  logic [AMBA_WORD-1:0] sh_data_q;
  logic [AMBA_WORD-1:0] sh_noise_q;
  logic [1:0]           sh_width_q;
  logic [3:1]           sh_vld_q;

  assign skip[1] = sh_vld_q[1] && (v_data  == sh_data_q);
  assign skip[2] = sh_vld_q[2] && (v_width == sh_width_q);
  assign skip[3] = sh_vld_q[3] && (v_noise == sh_noise_q);

  // A shadow becomes valid only when its ACCESS cycle completes, so a
  // reset in the middle of a write never leaves a stale valid shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_data_q  <= '0;
      sh_noise_q <= '0;
      sh_width_q <= '0;
      sh_vld_q   <= '0;
    end else if (timeout_evt) begin
      sh_vld_q <= '0;
    end else if (state_q == S_ACCESS) begin
      case (idx_q)
        R_DIN: begin
          sh_data_q   <= data_q;
          sh_vld_q[1] <= 1'b1;
        end
        R_CW: begin
          sh_width_q  <= width_q;
          sh_vld_q[2] <= 1'b1;
        end
        R_NOISE: begin
          sh_noise_q  <= noise_q;
          sh_vld_q[3] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign skip = '0;
`endif

  // First register to write, searching from index 'start' upward.
  // Falls back to CTRL, which is never skipped.
  function automatic logic [1:0] first_write(input int start, input logic [3:1] sk);
    logic [1:0] r;
    r = R_CTRL;
    // Descending scan: the lowest eligible index is the last to assign r.
    for (int i = 3; i >= 1; i--) begin
      if (i >= start && !sk[i]) r = 2'(i);
    end
    return r;
  endfunction

  logic [1:0]                 load_idx;
  logic [AMBA_ADDR_WIDTH-1:0] load_addr;
  logic [AMBA_WORD-1:0]       load_data;

  always_comb begin
    load_idx = in_idle ? first_write(1, skip) : first_write(int'(idx_q) + 1, skip);
    load_addr = AMBA_ADDR_WIDTH'(ADDR_BASE + 4 * int'(load_idx));
    case (load_idx)
      R_CTRL:  load_data = AMBA_WORD'(v_op);
      R_DIN:   load_data = v_data;
      R_CW:    load_data = AMBA_WORD'(v_width);
      default: load_data = v_noise;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= R_CTRL;
      op_q     <= '0;
      data_q   <= '0;
      width_q  <= '0;
      noise_q  <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= '0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      data_q   <= data_d;
      width_q  <= width_d;
      noise_q  <= noise_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    data_d   = data_q;
    width_d  = width_q;
    noise_d  = noise_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          width_d  = cmd_width;
          noise_d  = cmd_noise;
          idx_d    = load_idx;
          paddr_d  = load_addr;
          pwdata_d = load_data;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (idx_q == R_CTRL) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          idx_d    = load_idx;
          paddr_d  = load_addr;
          pwdata_d = load_data;
          state_d  = S_SETUP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Done has priority over the terminal count.
        if (operation_done) begin
          rdata_d = data_out;
          rerr_d  = num_of_errors;
          rto_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rerr_d  = '0;
          rto_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from state so an async reset drops them at once.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    PENABLE   = (state_q == S_ACCESS);
    PWRITE    = PSEL;
  end

  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_data    = rdata_q;
  assign rsp_errors  = rerr_q;
  assign rsp_timeout = rto_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Testbench for ecc_apb_sequencer: directed steps plus a random command
// loop, checked against a transaction-level reference model (expected
// APB write list, response contents and response latency).
module tb_ecc_apb_sequencer;

  localparam int AW   = 32;
  localparam int AAW  = 20;
  localparam int DW   = 32;
  localparam int BASE = 0;
  localparam int TO   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op, cmd_width;
  logic [AW-1:0]   cmd_data, cmd_noise;
  logic            rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_errors;
  logic            rsp_timeout, busy;
  logic [AAW-1:0]  PADDR;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PWDATA;
  logic [DW-1:0]   data_out;
  logic            operation_done;
  logic [1:0]      num_of_errors;

  ecc_apb_sequencer #(
    .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(AAW), .DATA_WIDTH(DW),
    .ADDR_BASE(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_width(cmd_width), .cmd_noise(cmd_noise),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // APB monitor: records each completed write and whether it was preceded
  // by a matching SETUP cycle with PWRITE high.
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  bit          mon_ok[$];
  int          apb_cyc = 0;
  bit          prev_setup = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always @(negedge clk) begin
    if (PSEL) apb_cyc++;
    if (PSEL && PENABLE) begin
      mon_addr.push_back(32'(PADDR));
      mon_data.push_back(PWDATA);
      mon_ok.push_back(prev_setup && prev_addr == 32'(PADDR) && prev_data == PWDATA && PWRITE);
    end
    prev_setup = PSEL && !PENABLE && PWRITE;
    prev_addr  = 32'(PADDR);
    prev_data  = PWDATA;
  end

  // Reference model shadow state: 0 DATA_IN, 1 CODEWORD_WIDTH, 2 NOISE
  bit          sh_v[3];
  logic [31:0] sh_val[3];

  function automatic logic [31:0] reg_addr(input int off);
    return 32'((BASE + off) % (1 << AAW));
  endfunction

  // done_mode: >=0 assert done that many cycles into WAIT_DONE,
  //            -1 never, -2 pulse only during the CTRL ACCESS cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input logic [1:0] width,
                         input logic [31:0] noise, input int done_mode, input logic [31:0] dout,
                         input logic [1:0] errs, input int hold);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] vals[3];
    bit          wr[3];
    bit          to_exp;
    int          n, k, wait_start, rsp_cyc, exp_lat;
    logic [31:0] e_data;
    logic [1:0]  e_err;

    vals[0] = data; vals[1] = 32'(width); vals[2] = noise;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b1;
`ifdef ECC_SEQ_SKIP_REDUNDANT_WR_EN
      if (sh_v[i] && sh_val[i] == vals[i]) wr[i] = 1'b0;
`endif
      if (wr[i]) begin
        ea.push_back(reg_addr(4 * (i + 1)));
        ed.push_back(vals[i]);
      end
    end
    ea.push_back(reg_addr(0));
    ed.push_back(32'(op));
    n       = ea.size();
    to_exp  = (done_mode < 0) || (done_mode >= TO);
    exp_lat = to_exp ? (2 * n + 1 + TO) : (2 * n + 2 + done_mode);
    e_data  = to_exp ? 32'h0 : dout;
    e_err   = to_exp ? 2'd0 : errs;

    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    mon_addr.delete(); mon_data.delete(); mon_ok.delete();
    apb_cyc   = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_width = width; cmd_noise = noise;
    @(negedge clk);
    // Command must be latched: scramble the inputs after acceptance.
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_data = $urandom; cmd_width = 2'($urandom); cmd_noise = $urandom;

    k = 1; wait_start = -1; rsp_cyc = -1;
    while (k < 400 && rsp_cyc < 0) begin
      operation_done = 1'b0;
      data_out       = $urandom;
      num_of_errors  = 2'($urandom);
      if (rsp_valid) begin
        rsp_cyc = k;
      end else begin
        if (busy && !PSEL) begin
          if (wait_start < 0) wait_start = k;
          if (done_mode >= 0 && k - wait_start == done_mode) begin
            operation_done = 1'b1;
            data_out       = dout;
            num_of_errors  = errs;
          end
        end
        if (done_mode == -2 && PSEL && PENABLE && 32'(PADDR) == reg_addr(0))
          operation_done = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    operation_done = 1'b0;

    check("rsp_seen", 64'(rsp_cyc > 0), 64'd1);
    if (rsp_cyc <= 0) return;

    check("wait_entry_cycle", 64'(wait_start), 64'(2 * n + 1));
    check("rsp_latency", 64'(rsp_cyc), 64'(exp_lat));
    check("apb_cycles", 64'(apb_cyc), 64'(2 * n));
    check("apb_write_count", 64'(mon_addr.size()), 64'(n));
    for (int i = 0; i < n && i < mon_addr.size(); i++) begin
      check("apb_addr", 64'(mon_addr[i]), 64'(ea[i]));
      check("apb_data", 64'(mon_data[i]), 64'(ed[i]));
      check("apb_setup_access", 64'(mon_ok[i]), 64'd1);
    end
    check("rsp_data", 64'(rsp_data), 64'(e_data));
    check("rsp_errors", 64'(rsp_errors), 64'(e_err));
    check("rsp_timeout", 64'(rsp_timeout), 64'(to_exp));
    check("resp_busy", 64'(busy), 64'd1);
    check("resp_cmd_ready", 64'(cmd_ready), 64'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_data", 64'(rsp_data), 64'(e_data));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3; i++) begin
      if (wr[i]) begin
        sh_v[i]   = 1'b1;
        sh_val[i] = vals[i];
      end
    end
    if (to_exp) for (int i = 0; i < 3; i++) sh_v[i] = 1'b0;

    $display("cmd op=%0d data=%08h width=%0d noise=%08h done_mode=%0d writes=%0d latency=%0d rsp_data=%08h err=%0d to=%0d",
             op, data, width, noise, done_mode, n, rsp_cyc, rsp_data, rsp_errors, rsp_timeout);
  endtask

  // Reset asserted during the NOISE ACCESS cycle of a fresh command.
  task automatic reset_mid();
    bit found;
    found = 0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 32'h7E57_0001; cmd_width = 2'd2; cmd_noise = 32'h5A5A_1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (PSEL && PENABLE && 32'(PADDR) == reg_addr(12)) found = 1;
      else @(negedge clk);
    end
    check("noise_access_seen", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sh_v[i] = 1'b0;
    @(negedge clk);
    $display("reset during NOISE access: psel=%0d penable=%0d busy=%0d", PSEL, PENABLE, busy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dm;
    logic [31:0] pool_d[2];
    logic [31:0] pool_n[2];
    pool_d[0] = 32'h0000_00A5; pool_d[1] = 32'h1234_5678;
    pool_n[0] = 32'h0;         pool_n[1] = 32'h1;
    cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_width = 0; cmd_noise = 0;
    rsp_ready = 0; data_out = 0; operation_done = 0; num_of_errors = 0;
    for (int i = 0; i < 3; i++) begin sh_v[i] = 0; sh_val[i] = '0; end

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_psel", 64'(PSEL), 64'd0);
    check("reset_penable", 64'(PENABLE), 64'd0);
    check("reset_pwrite", 64'(PWRITE), 64'd0);
    check("reset_paddr", 64'(PADDR), 64'd0);
    check("reset_pwdata", 64'(PWDATA), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_errors", 64'(rsp_errors), 64'd0);
    check("reset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    $display("reset state: cmd_ready=%0d busy=%0d psel=%0d", cmd_ready, busy, PSEL);
    rst = 1'b1;
    @(negedge clk);

    run_cmd(2'd0, 32'h0000_00A5, 2'd0, 32'h0, 2, $urandom, 2'd0, 0);
    run_cmd(2'd1, $urandom, 2'd1, 32'h0000_0001, 0, $urandom, 2'd1, 5);
    run_cmd(2'd2, $urandom, 2'd2, $urandom, -1, $urandom, 2'd2, 1);
    run_cmd(2'd0, $urandom, 2'd0, $urandom, -2, $urandom, 2'd1, 0);
    run_cmd(2'd1, $urandom, 2'd3, $urandom, TO - 1, $urandom, 2'd3, 0);
    run_cmd(2'd2, 32'h1111_2222, 2'd2, 32'h0000_0003, 1, $urandom, 2'd0, 0);
    run_cmd(2'd2, 32'h1111_2222, 2'd2, 32'h0000_0003, 1, $urandom, 2'd0, 0);
    reset_mid();
    run_cmd(2'd1, 32'h7E57_0001, 2'd2, 32'h5A5A_1234, 3, $urandom, 2'd2, 0);

    for (int t = 0; t < 16; t++) begin
      dm = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      run_cmd(2'($urandom_range(0, 2)), pool_d[$urandom_range(0, 1)], 2'($urandom_range(0, 3)),
              pool_n[$urandom_range(0, 1)], dm, $urandom, 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
